// File: rtl/ctrl_random_check.sv
// Receive-side checker for the 64-bit LFSR matrix stream (lock, mismatch pulse, error count).
// Define CTRL_RANDOM_CHECK_FIRST_ERR_EN to add first-error lane capture outputs.
module ctrl_random_check #(
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int LOCK_BEATS  = 4,
  parameter int LOSS_THRESH = 4,
  parameter int COUNT_W     = 16,
  localparam int DW = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      data_in,
  input  logic               data_valid,
  input  logic               err_clr,
  output logic               locked,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] err_count
`ifdef CTRL_RANDOM_CHECK_FIRST_ERR_EN
  ,
  output logic [$clog2(DW/WEIGHT_BW)-1:0] first_err_lane,
  output logic                            first_err_vld
`endif
);

  localparam int MRW = $clog2(LOCK_BEATS + 1);
  localparam int LRW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t             state_q;
  logic [DW-1:0]      exp_q;
  logic [DW-1:0]      exp_d;
  logic [MRW-1:0]     match_run_q;
  logic [LRW-1:0]     miss_run_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic [COUNT_W-1:0] err_count_q;
  logic [COUNT_W-1:0] err_count_d;
  logic [63:0]        lo;
  logic               match;
  logic               count_hit;

  // Next window: shift up one word, newest word is one LFSR step on.
  assign lo    = data_in[63:0];
  assign exp_d = {data_in[DW-65:0], lo[62:0],
                  lo[63] ^ lo[62] ^ lo[60] ^ lo[59]};
  assign match = (data_in == exp_q);
  assign count_hit = data_valid && (state_q == LOCKED) && !match;

  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = COUNT_W'(count_hit);
    end else if (count_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= count_hit;
      if (data_valid) begin
        unique case (state_q)
          HUNT: begin
            // An all-zero word is a fixed point of the LFSR; never lock onto it.
            if (lo != 64'd0) begin
              exp_q       <= exp_d;
              match_run_q <= '0;
              state_q     <= VERIFY;
            end
          end
          VERIFY: begin
            exp_q <= exp_d;
            if (!match) begin
              state_q <= HUNT;
            end else if (match_run_q == MRW'(LOCK_BEATS - 1)) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              miss_run_q  <= '0;
              match_run_q <= '0;
            end else begin
              match_run_q <= match_run_q + 1'b1;
            end
          end
          LOCKED: begin
            exp_q <= exp_d;
            if (match) begin
              miss_run_q <= '0;
            end else if (miss_run_q == LRW'(LOSS_THRESH - 1)) begin
              state_q    <= HUNT;
              locked_q   <= 1'b0;
              miss_run_q <= '0;
            end else begin
              miss_run_q <= miss_run_q + 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef CTRL_RANDOM_CHECK_FIRST_ERR_EN
  localparam int LANES = DW / WEIGHT_BW;
  localparam int LW    = $clog2(LANES);

  logic [DW-1:0] diff;
  logic [LW-1:0] lane_d;
  logic [LW-1:0] lane_q;
  logic          fe_vld_q;

  assign diff = data_in ^ exp_q;

  // Scan high to low so the lowest differing lane wins.
  always_comb begin
    lane_d = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (|diff[i*WEIGHT_BW +: WEIGHT_BW]) begin
        lane_d = LW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q   <= '0;
      fe_vld_q <= 1'b0;
    end else if (err_clr) begin
      lane_q   <= count_hit ? lane_d : '0;
      fe_vld_q <= count_hit;
    end else if (count_hit && !fe_vld_q) begin
      lane_q   <= lane_d;
      fe_vld_q <= 1'b1;
    end
  end

  assign first_err_lane = lane_q;
  assign first_err_vld  = fe_vld_q;
`endif

endmodule

// File: tb/tb_ctrl_random_check.sv
// Directed bench for ctrl_random_check: lock, error, loss, idle and saturation cases.
// Runs a default-width instance and a COUNT_W=4 instance on the same stream.
module tb_ctrl_random_check;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          err_clr;
  logic          locked;
  logic          err_pulse;
  logic [15:0]   err_count;
  logic          locked4;
  logic          err_pulse4;
  logic [3:0]    err_count4;
`ifdef CTRL_RANDOM_CHECK_FIRST_ERR_EN
  logic [5:0]    fe_lane;
  logic          fe_vld;
  logic [5:0]    fe_lane4;
  logic          fe_vld4;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] g_win;

  always #5 clk = ~clk;

  ctrl_random_check u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
`ifdef CTRL_RANDOM_CHECK_FIRST_ERR_EN
    .first_err_lane (fe_lane),
    .first_err_vld  (fe_vld),
`endif
    .err_count  (err_count)
  );

  ctrl_random_check #(.COUNT_W(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .err_clr    (err_clr),
    .locked     (locked4),
    .err_pulse  (err_pulse4),
`ifdef CTRL_RANDOM_CHECK_FIRST_ERR_EN
    .first_err_lane (fe_lane4),
    .first_err_vld  (fe_vld4),
`endif
    .err_count  (err_count4)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] nxt(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
  endfunction

  function automatic logic [DW-1:0] step(input logic [DW-1:0] w);
    return {w[DW-65:0], nxt(w[63:0])};
  endfunction

  // One cycle: drive at negedge, outputs settled #1 after posedge.
  task automatic beat(input logic [DW-1:0] d, input logic v,
                      input logic c);
    @(negedge clk);
    data_in    = d;
    data_valid = v;
    err_clr    = c;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic gen(input logic [DW-1:0] mask, input logic c);
    beat(g_win ^ mask, 1'b1, c);
    g_win = step(g_win);
  endtask

  task automatic clr();
    beat(data_in, 1'b0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic relock(input string tag);
    for (int i = 1; i <= 5; i++) begin
      gen('0, 1'b0);
      if (i == 4) chk({tag, "_pre"}, locked, 1'b0);
      if (i == 5) chk({tag, "_lock"}, locked, 1'b1);
    end
  endtask

  initial begin
    logic          seen;
    logic [DW-1:0] m;
    logic [15:0]   pat;
    int            vc;

    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    err_clr    = 1'b0;
    g_win      = '0;
    g_win[63:0] = 64'hACE1;
    repeat (8) g_win = step(g_win);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_pulse", err_pulse, 1'b0);
    chk("rst_count", err_count, 16'd0);

    // 1: clean stream locks after 1+4 beats and stays error free
    relock("t1");
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      gen('0, 1'b0);
      if (err_pulse) seen = 1'b1;
    end
    chk("t1_pulse", seen, 1'b0);
    chk("t1_count", err_count, 16'd0);
    chk("t1_locked", locked, 1'b1);

    // 2: one bit-0 flip gives two counted mismatches
    gen(512'd1, 1'b0);
    chk("t2_p1", err_pulse, 1'b1);
    chk("t2_c1", err_count, 16'd1);
    gen('0, 1'b0);
    chk("t2_p2", err_pulse, 1'b1);
    chk("t2_c2", err_count, 16'd2);
    gen('0, 1'b0);
    chk("t2_p3", err_pulse, 1'b0);
    chk("t2_c3", err_count4, 4'd2);
    chk("t2_locked", locked, 1'b1);

    // 3: four inverted beats drop lock, then relock
    clr();
    chk("t3_clr", err_count, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      gen('1, 1'b0);
      if (i == 3) chk("t3_hold", locked, 1'b1);
    end
    chk("t3_lost", locked, 1'b0);
    chk("t3_count", err_count, 16'd4);
    relock("t3");
    chk("t3_count2", err_count, 16'd4);

    // 5: saturation at COUNT_W=4, then clear with a same-cycle mismatch
    clr();
    for (int i = 0; i < 10; i++) begin
      gen(512'd1, 1'b0);
      gen('0, 1'b0);
      gen('0, 1'b0);
    end
    chk("t5_sat4", err_count4, 4'd15);
    chk("t5_cnt16", err_count, 16'd20);
    chk("t5_locked", locked4, 1'b1);
    gen(512'd1, 1'b1);
    chk("t5_clr4", err_count4, 4'd1);
    chk("t5_clr16", err_count, 16'd1);
    gen('0, 1'b0);
    chk("t5_next", err_count4, 4'd2);
    gen('0, 1'b0);
    chk("t5_quiet", err_pulse, 1'b0);

    // 6: reset while locked with errors, zeros ignored in HUNT, relock
    clr();
    gen(512'd1, 1'b0);
    gen('0, 1'b0);
    gen('0, 1'b0);
    gen(512'd1, 1'b0);
    chk("t6_c3", err_count, 16'd3);
    chk("t6_p", err_pulse, 1'b1);
    pulse_reset();
    chk("t6_locked", locked, 1'b0);
    chk("t6_count", err_count, 16'd0);
    chk("t6_pulse", err_pulse, 1'b0);
    repeat (3) beat('0, 1'b1, 1'b0);
    chk("t6_zero", locked, 1'b0);
    relock("t6");

    // 4: gapped valid with held data; lock counts valid beats only
    pulse_reset();
    pat = 16'hB2D6;
    vc  = 0;
    for (int i = 0; i < 16; i++) begin
      if (pat[i]) begin
        gen('0, 1'b0);
        vc++;
      end else begin
        beat(data_in, 1'b0, 1'b0);
      end
      chk($sformatf("t4_lock%0d", i), locked, (vc >= 5) ? 1'b1 : 1'b0);
      chk($sformatf("t4_pulse%0d", i), err_pulse, 1'b0);
    end
    chk("t4_count", err_count, 16'd0);

`ifdef CTRL_RANDOM_CHECK_FIRST_ERR_EN
    clr();
    chk("fe_vld0", fe_vld, 1'b0);
    m = '0;
    m[47:40] = 8'hFF;
    gen(m, 1'b0);
    chk("fe_lane", fe_lane, 6'd5);
    chk("fe_vld", fe_vld, 1'b1);
    gen('0, 1'b0);
    chk("fe_hold", fe_lane4, 6'd5);
    gen('0, 1'b0);
    clr();
    chk("fe_clr", fe_vld, 1'b0);
`else
    m = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
